// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: two-stage valid/ready ALU pipe (operand regs -> ALU -> result regs).
// Define ALU_SHIFT_EN to build the SHL/SHR/SRA shifter; otherwise shift codes are illegal.
module alu_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [5:0]       in_alufn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_z,
  output logic             out_v,
  output logic             out_n,
  output logic             out_illegal
);
  logic [WIDTH-1:0] r_a, r_b;
  logic [5:0]       r_fn;
  logic             r_s1_valid;
  logic             w_s2_free, w_adv, w_acc;
  logic [WIDTH-1:0] w_bx, w_sum, w_res;
  logic             w_z, w_v, w_n, w_cmp, w_arith, w_ill;
  assign w_s2_free = !out_valid || out_ready;
  assign w_adv     = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_acc     = in_valid && in_ready;
  assign w_bx  = r_b ^ {WIDTH{r_fn[0]}};
  assign w_sum = r_a + w_bx + {{(WIDTH-1){1'b0}}, r_fn[0]};
  assign w_z   = (w_sum == '0);
  assign w_n   = w_sum[WIDTH-1];
  assign w_v   = (r_a[WIDTH-1] & w_bx[WIDTH-1] & ~w_sum[WIDTH-1]) |
                 (~r_a[WIDTH-1] & ~w_bx[WIDTH-1] & w_sum[WIDTH-1]);
  assign w_cmp = (r_fn[2:1] == 2'b01) ? w_z :
                 (r_fn[2:1] == 2'b10) ? (w_n ^ w_v) :
                 (r_fn[2:1] == 2'b11) ? (w_z | (w_n ^ w_v)) : 1'b0;
`ifdef ALU_SHIFT_EN
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_sra;
  assign w_sh  = r_b[SW-1:0];
  assign w_sra = $signed(r_a) >>> w_sh;
`endif
  always_comb begin
    w_res   = '0;
    w_arith = 1'b0;
    w_ill   = 1'b0;
    case (r_fn)
      6'b000000, 6'b000001: begin
        w_res   = w_sum;
        w_arith = 1'b1;
      end
      6'b110011, 6'b110101, 6'b110111: begin
        w_res   = {{(WIDTH-1){1'b0}}, w_cmp};
        w_arith = 1'b1;
      end
      6'b011000: w_res = r_a & r_b;
      6'b011110: w_res = r_a | r_b;
      6'b010110: w_res = r_a ^ r_b;
      6'b011010: w_res = r_a;
`ifdef ALU_SHIFT_EN
      6'b100000: w_res = r_a << w_sh;
      6'b100001: w_res = r_a >> w_sh;
      6'b100011: w_res = w_sra;
`endif
      default:   w_ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_fn       <= '0;
    end else if (w_acc) begin
      r_s1_valid <= 1'b1;
      r_a        <= in_a;
      r_b        <= in_b;
      r_fn       <= in_alufn;
    end else if (w_adv) begin
      r_s1_valid <= 1'b0;
    end
  end
  // Stage-2 data only changes on an advance, so a stalled result stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_z       <= 1'b0;
      out_v       <= 1'b0;
      out_n       <= 1'b0;
      out_illegal <= 1'b0;
    end else if (w_adv) begin
      out_valid   <= 1'b1;
      out_result  <= w_res;
      out_z       <= w_arith & w_z;
      out_v       <= w_arith & w_v;
      out_n       <= w_arith & w_n;
      out_illegal <= w_ill;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe_stage.sv
// tb_alu_pipe_stage: directed-vector bench for alu_pipe_stage at WIDTH=8.
module tb_alu_pipe_stage;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [5:0]   in_alufn = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_z, out_v, out_n, out_illegal;
  int           n_vec = 0, n_bad = 0;
  logic [W-1:0] q[$];
  alu_pipe_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_alufn(in_alufn), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_z(out_z),
    .out_v(out_v), .out_n(out_n), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid && out_ready) q.push_back(out_result);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] fn);
    bit ok = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_alufn = fn;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  // flags packed as {z,v,n,illegal}
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [5:0] fn, input logic [W-1:0] er, input logic [3:0] ef);
    out_ready = 1'b1;
    send(a, b, fn);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"}, out_result, er);
    check({tag, "_flags"}, {out_z, out_v, out_n, out_illegal}, ef);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_out", {out_result, out_z, out_v, out_n, out_illegal}, 0);
    run_op("sub", 8'd3, 8'd2, 6'b000001, 8'd1, 4'b0000);
    run_op("cmplt_t", 8'd1, 8'd2, 6'b110101, 8'd1, 4'b0010);
    run_op("cmple", 8'h80, 8'h01, 6'b110111, 8'd1, 4'b0100);
    run_op("cmpeq", 8'd5, 8'd5, 6'b110011, 8'd1, 4'b1000);
    run_op("cmplt_f", 8'd3, 8'd2, 6'b110101, 8'd0, 4'b0000);
    run_op("add_ovf", 8'h7F, 8'h01, 6'b000000, 8'h80, 4'b0110);
    run_op("sub_ovf", 8'h80, 8'h01, 6'b000001, 8'h7F, 4'b0100);
    run_op("and", 8'hF0, 8'h3C, 6'b011000, 8'h30, 4'b0000);
    run_op("or", 8'hF0, 8'h3C, 6'b011110, 8'hFC, 4'b0000);
    run_op("xor", 8'hF0, 8'h3C, 6'b010110, 8'hCC, 4'b0000);
    run_op("pass_a", 8'hF0, 8'h3C, 6'b011010, 8'hF0, 4'b0000);
    run_op("illegal", 8'h12, 8'h34, 6'b000010, 8'h00, 4'b0001);
`ifdef ALU_SHIFT_EN
    run_op("sra", 8'h90, 8'd2, 6'b100011, 8'hE4, 4'b0000);
    run_op("shl", 8'h81, 8'd1, 6'b100000, 8'h02, 4'b0000);
    run_op("shr", 8'h81, 8'd1, 6'b100001, 8'h40, 4'b0000);
`else
    run_op("sra", 8'h90, 8'd2, 6'b100011, 8'h00, 4'b0001);
    run_op("shl", 8'h81, 8'd1, 6'b100000, 8'h00, 4'b0001);
`endif
    @(posedge clk);
    #1 out_ready = 1'b0;
    q.delete();
    send(8'd1, 8'd1, 6'b000000);
    send(8'd2, 8'd2, 6'b000000);
    check("bp_ready_low", in_ready, 0);
    check("bp_valid", out_valid, 1);
    check("bp_res0", out_result, 8'd2);
    fork
      begin
        send(8'd3, 8'd3, 6'b000000);
        send(8'd4, 8'd4, 6'b000000);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold", out_result, 8'd2);
        check("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", q.size(), 4);
    for (int i = 0; i < 4 && i < q.size(); i++)
      check($sformatf("bp_order%0d", i), q[i], 2 * (i + 1));
    check("bp_drained", out_valid, 0);
    out_ready = 1'b0;
    send(8'd7, 8'd7, 6'b000000);
    send(8'd9, 8'd9, 6'b000000);
    check("mid_full", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_valid", out_valid, 0);
    check("mid_ready", in_ready, 1);
    check("mid_out", {out_result, out_z, out_v, out_n, out_illegal}, 0);
    q.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_ghost", q.size(), 0);
    check("mid_valid_end", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
